// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

  // Controller states: waiting for a request, or retiring multiplier bits.
  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  // Smallest r with 2**r >= value; sizes the bit counter so it can hold N.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage : seq_mult_pkg

// File: rtl/seq_mult_datapath.sv
// Accumulator/multiplier shift register and add/subtract step of the
// shift-add multiplier. Sequenced by load/step/last strobes from the top.
module seq_mult_datapath
  import seq_mult_pkg::*;
#(
  parameter int M = 8,
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic           last,
  input  logic           is_signed,
  input  logic [M-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [M+N-1:0] prod_next
);

  logic [M:0]   acc;
  logic [N-1:0] q;
  logic [M-1:0] mcand;
  logic         mode;

  logic [M:0]   ext;
  logic [M:0]   sum;
  logic [M:0]   acc_next;
  logic [N-1:0] q_next;
  logic         fill;

  // One multiplier bit: conditional add (or subtract for the negative-weight
  // sign bit of a signed multiplier), then shift {acc,q} right by one.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    ext      = mode ? {mcand[M-1], mcand} : {1'b0, mcand};
    sum      = acc;
    if (q[0]) begin
      sum = (mode && last) ? (acc - ext) : (acc + ext);
    end
    fill     = mode ? sum[M] : 1'b0;
    acc_next = {fill, sum[M:1]};
    q_next   = {sum[0], q[N-1:1]};
  end

  // The final product is the low M bits of the shifted accumulator above
  // the fully shifted multiplier register.
  assign prod_next = {acc_next[M-1:0], q_next};

  // Operand capture on accept, one shift per CALC cycle.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the working registers are reset too, so a mid-operation reset
    // leaves no stale partial result and the block comes up deterministic.
    if (rst) begin
      acc   <= '0;
      q     <= '0;
      mcand <= '0;
      mode  <= 1'b0;
    end else if (load) begin
      acc   <= '0;
      q     <= b;
      mcand <= a;
      mode  <= is_signed;
    end else if (step) begin
      acc   <= acc_next;
      q     <= q_next;
    end
  end

endmodule : seq_mult_datapath

// File: rtl/seq_multiplier.sv
// Self-sequenced M x N shift-add multiplier with start/done handshake and a
// per-operation signed/unsigned mode. One multiplier bit per clock.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int M = 8,
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           is_signed,
  input  logic [M-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           ready,
  output logic           done,
  output logic [M+N-1:0] product
);

  localparam int CW = clog2(N + 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            load;
  logic            step;
  logic            last;
  logic [M+N-1:0]  prod_next;

  // Requests are only seen in IDLE; anything arriving mid-calculation is dropped.
  assign ready = (state == IDLE);
  assign load  = ready && start;
  assign step  = (state == CALC);
  assign last  = (cnt == CW'(N - 1));

  seq_mult_datapath #(
    .M(M),
    .N(N)
  ) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .last      (last),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .prod_next (prod_next)
  );

  // Controller: bit counter, state, single-cycle done and held product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            product <= prod_next;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: an 8x8 and a 12x4 instance share the
// clock; stimulus pushes expected products, monitors pop them on done.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 8x8 instance
  logic        start8, sgn8, ready8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;
  // 12x4 instance
  logic        start12, sgn12, ready12, done12;
  logic [11:0] a12;
  logic [3:0]  b12;
  logic [15:0] prod12;

  seq_multiplier #(.M(8), .N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8), .a(a8), .b(b8),
    .ready(ready8), .done(done8), .product(prod8)
  );

  seq_multiplier #(.M(12), .N(4)) dut12 (
    .clk(clk), .rst(rst), .start(start12), .is_signed(sgn12), .a(a12), .b(b12),
    .ready(ready12), .done(done12), .product(prod12)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp8_q[$];
  logic [15:0] exp12_q[$];
  logic [15:0] last8, last12;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference products, computed with the simulator's own multiply.
  function automatic logic [15:0] model8(input logic s, input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] p;
    if (s) p = $signed(a) * $signed(b);
    else   p = $signed({8'h00, a} * {8'h00, b});
    return p;
  endfunction

  function automatic logic [15:0] model12(input logic s, input logic [11:0] a, input logic [3:0] b);
    logic signed [15:0] p;
    if (s) p = $signed(a) * $signed(b);
    else   p = $signed({4'h0, a} * {12'h000, b});
    return p;
  endfunction

  // Monitors: compare on done, require the product to hold otherwise.
  always @(negedge clk) begin
    if (rst) begin
      last8 = '0;
    end else if (done8) begin
      if (exp8_q.size() == 0) begin
        check("done8_unexpected", {31'd0, done8}, 32'd0);
      end else begin
        check("prod8", {16'd0, prod8}, {16'd0, exp8_q.pop_front()});
      end
      last8 = prod8;
    end else begin
      check("hold8", {16'd0, prod8}, {16'd0, last8});
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      last12 = '0;
    end else if (done12) begin
      if (exp12_q.size() == 0) begin
        check("done12_unexpected", {31'd0, done12}, 32'd0);
      end else begin
        check("prod12", {16'd0, prod12}, {16'd0, exp12_q.pop_front()});
      end
      last12 = prod12;
    end else begin
      check("hold12", {16'd0, prod12}, {16'd0, last12});
    end
  end

  // Issue one 8x8 op at a negedge; optionally wait for done and check timing.
  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp, input bit push, input bit wait_done);
    int t, lat, busy;
    t = 0;
    while (!ready8 && t < 100) begin @(negedge clk); t++; end
    if (!ready8) check("ready8_timeout", {31'd0, ready8}, 32'd1);
    start8 = 1'b1; sgn8 = s; a8 = a; b8 = b;
    if (push) exp8_q.push_back(exp);
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
    if (wait_done) begin
      lat = 1; busy = 0;
      while (!done8 && lat < 50) begin
        if (!ready8) busy++;
        @(negedge clk);
        lat++;
      end
      check("lat8", lat, 9);
      check("busy8", busy, 8);
      check("ready8_at_done", {31'd0, ready8}, 32'd1);
    end
  endtask

  task automatic op12(input logic s, input logic [11:0] a, input logic [3:0] b,
                      input logic [15:0] exp, input bit wait_done);
    int t, lat;
    t = 0;
    while (!ready12 && t < 100) begin @(negedge clk); t++; end
    if (!ready12) check("ready12_timeout", {31'd0, ready12}, 32'd1);
    start12 = 1'b1; sgn12 = s; a12 = a; b12 = b;
    exp12_q.push_back(exp);
    @(negedge clk);
    start12 = 1'b0; a12 = 12'($urandom); b12 = 4'($urandom); sgn12 = 1'($urandom);
    if (wait_done) begin
      lat = 1;
      while (!done12 && lat < 50) begin @(negedge clk); lat++; end
      check("lat12", lat, 5);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    start12 = 1'b0; sgn12 = 1'b0; a12 = '0; b12 = '0;
    #1;
    check("rst_ready8", {31'd0, ready8}, 32'd1);
    check("rst_done8",  {31'd0, done8},  32'd0);
    check("rst_prod8",  {16'd0, prod8},  32'd0);
    check("rst_prod12", {16'd0, prod12}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed 8x8 vectors
    op8(1'b0, 8'd255, 8'd255, 16'hFE01, 1'b1, 1'b1);
    op8(1'b1, 8'h80,  8'h80,  16'h4000, 1'b1, 1'b1);
    op8(1'b1, 8'hFF,  8'h01,  16'hFFFF, 1'b1, 1'b1);
    op8(1'b1, 8'h7F,  8'h80,  16'hC080, 1'b1, 1'b1);
    // Issued in the done cycle of the previous op: must be accepted
    op8(1'b0, 8'd3,   8'd5,   16'd15,   1'b1, 1'b1);

    // Directed 12x4 vectors
    op12(1'b1, 12'h800, 4'h8, 16'h4000, 1'b1);
    op12(1'b0, 12'hFFF, 4'hF, 16'hEFF1, 1'b1);

    // Start pulsed mid-CALC with other operands must be ignored
    op8(1'b0, 8'd10, 8'd20, 16'd200, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    start8 = 1'b1; a8 = 8'd99; b8 = 8'd99; sgn8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 20 && !done8; i++) @(negedge clk);
    check("busy_start_done", {31'd0, done8}, 32'd1);
    repeat (12) @(negedge clk);

    // Reset during CALC cycle 4: aborted op must never complete
    op8(1'b0, 8'd77, 8'd91, 16'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready8", {31'd0, ready8}, 32'd1);
    check("midrst_prod8",  {16'd0, prod8},  32'd0);
    check("midrst_done8",  {31'd0, done8},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    op8(1'b0, 8'd0, 8'd200, 16'd0, 1'b1, 1'b1);

    // Random regression on both instances in parallel
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          logic s; logic [7:0] ra, rb;
          s = 1'($urandom); ra = 8'($urandom); rb = 8'($urandom);
          op8(s, ra, rb, model8(s, ra, rb), 1'b1, 1'b1);
        end
      end
      begin
        for (int i = 0; i < 2000; i++) begin
          logic s; logic [11:0] ra; logic [3:0] rb;
          s = 1'($urandom); ra = 12'($urandom); rb = 4'($urandom);
          op12(s, ra, rb, model12(s, ra, rb), 1'b1);
        end
      end
    join

    repeat (12) @(negedge clk);
    check("q8_drained",  exp8_q.size(),  0);
    check("q12_drained", exp12_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_seq_multiplier
